// File: rtl/operand_fetch_if.sv
// ---------------------------------------------------------------------------
// operand_fetch_if
//   Bundle of every handshake and bus signal around the operand-fetch
//   controller. The signal groups are:
//     decode    -> in_valid/in_ready, in_rs1/in_rs2/in_rd,
//                  in_use_rs1/in_use_rs2/in_writes_rd
//     reg file  <- rf_enable, rf_read1/2, rf_index1/2
//                -> rf_data1/2 (registered, 1-cycle latency)
//                <- rf_write, rf_index_write, rf_data_write
//     writeback -> wb_valid, wb_rd, wb_data
//     execute   <- out_valid, out_op1/2, out_rd, out_writes_rd
//                -> out_ready
//   The slave modport is the controller. The master modport is the
//   surrounding pipeline (decode, register file, writeback and execute).
// ---------------------------------------------------------------------------
interface operand_fetch_if #(
  parameter int XLEN = 32,
  parameter int IW   = 5
);
  // decode -> controller
  logic            in_valid;
  logic            in_ready;
  logic [IW-1:0]   in_rs1;
  logic [IW-1:0]   in_rs2;
  logic [IW-1:0]   in_rd;
  logic            in_use_rs1;
  logic            in_use_rs2;
  logic            in_writes_rd;

  // register-file read ports
  logic            rf_enable;
  logic            rf_read1;
  logic            rf_read2;
  logic [IW-1:0]   rf_index1;
  logic [IW-1:0]   rf_index2;
  logic [XLEN-1:0] rf_data1;
  logic [XLEN-1:0] rf_data2;

  // register-file write port
  logic            rf_write;
  logic [IW-1:0]   rf_index_write;
  logic [XLEN-1:0] rf_data_write;

  // writeback
  logic            wb_valid;
  logic [IW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;

  // controller -> execute
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_op1;
  logic [XLEN-1:0] out_op2;
  logic [IW-1:0]   out_rd;
  logic            out_writes_rd;

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_use_rs1, in_use_rs2, in_writes_rd,
    output in_ready,
    output rf_enable, rf_read1, rf_read2, rf_index1, rf_index2,
    input  rf_data1, rf_data2,
    output rf_write, rf_index_write, rf_data_write,
    input  wb_valid, wb_rd, wb_data,
    output out_valid, out_op1, out_op2, out_rd, out_writes_rd,
    input  out_ready
  );

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_use_rs1, in_use_rs2, in_writes_rd,
    input  in_ready,
    input  rf_enable, rf_read1, rf_read2, rf_index1, rf_index2,
    output rf_data1, rf_data2,
    input  rf_write, rf_index_write, rf_data_write,
    output wb_valid, wb_rd, wb_data,
    input  out_valid, out_op1, out_op2, out_rd, out_writes_rd,
    output out_ready
  );
endinterface

// File: rtl/operand_fetch.sv
// ---------------------------------------------------------------------------
// operand_fetch
//   Requester-side controller for a register file with 2 registered read
//   ports and 1 write port. It takes one decoded instruction at a time,
//   issues the register reads, forwards any writeback that lands in the
//   same cycle as the read, and hands the operand pair to execute.
//   A scoreboard of pending destination writes stalls RAW and WAW hazards.
//
//   Ports:
//     clk  - clock
//     rst  - asynchronous, active-low reset
//     bus  - operand_fetch_if.slave (decode, register file, writeback and
//            execute signals; see the interface for the signal list)
//
//   Timing: accept in cycle N, register-file data in cycle N+1 (READ),
//   out_valid in cycle N+2 (OUT). One instruction per 3 cycles at best.
// ---------------------------------------------------------------------------
module operand_fetch #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input logic             clk,
  input logic             rst,
  operand_fetch_if.slave  bus
);

  localparam int IW = $clog2(NREG);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t          state;
  logic            rf_enable_q;

  // Scoreboard: one bit per architectural register with a write in flight.
  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_next;

  // Instruction captured at accept, consumed in READ.
  logic [IW-1:0]   rs1_q;
  logic [IW-1:0]   rs2_q;
  logic [IW-1:0]   rd_q;
  logic            use1_q;
  logic            use2_q;
  logic            writes_q;
  logic            fwd1_q;
  logic            fwd2_q;
  logic [XLEN-1:0] fwd_data_q;

  // Registered outputs to execute.
  logic            out_valid_q;
  logic [XLEN-1:0] op1_q;
  logic [XLEN-1:0] op2_q;
  logic [IW-1:0]   out_rd_q;
  logic            out_writes_q;

  logic            clr_rs1;
  logic            clr_rs2;
  logic            clr_rd;
  logic            hazard;
  logic            in_ready;
  logic            accept;
  logic [XLEN-1:0] op1_sel;
  logic [XLEN-1:0] op2_sel;

  // A writeback landing this cycle retires the pending write, so it must
  // not stall; its value is picked up through the forwarding path instead.
  assign clr_rs1 = bus.wb_valid && (bus.wb_rd == bus.in_rs1);
  assign clr_rs2 = bus.wb_valid && (bus.wb_rd == bus.in_rs2);
  assign clr_rd  = bus.wb_valid && (bus.wb_rd == bus.in_rd);

  assign hazard = (bus.in_use_rs1   && pend[bus.in_rs1] && !clr_rs1) ||
                  (bus.in_use_rs2   && pend[bus.in_rs2] && !clr_rs2) ||
                  (bus.in_writes_rd && pend[bus.in_rd]  && !clr_rd);

  assign in_ready = (state == IDLE) && rf_enable_q && !hazard;
  assign accept   = bus.in_valid && in_ready;

  // Scoreboard update. Set is applied after clear so a same-cycle
  // set/clear of one register leaves it pending (the new writer owns it).
  // NOTE: every variable assigned in always_comb gets a default first;
  // a path that leaves it unassigned would infer a latch.
  always_comb begin
    pend_next = pend;
    if (bus.wb_valid) begin
      pend_next[bus.wb_rd] = 1'b0;
    end
    if (accept && bus.in_writes_rd && (bus.in_rd != '0)) begin
      pend_next[bus.in_rd] = 1'b1;
    end
    pend_next[0] = 1'b0;
  end

  // Operand select in READ: x0 or an unused source reads as zero, then a
  // forwarded writeback wins over the register file, whose read was
  // issued before that write became visible.
  always_comb begin
    op1_sel = bus.rf_data1;
    if ((rs1_q == '0) || !use1_q) begin
      op1_sel = '0;
    end else if (fwd1_q) begin
      op1_sel = fwd_data_q;
    end
  end

  always_comb begin
    op2_sel = bus.rf_data2;
    if ((rs2_q == '0) || !use2_q) begin
      op2_sel = '0;
    end else if (fwd2_q) begin
      op2_sel = fwd_data_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      rf_enable_q  <= 1'b0;
      pend         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      use1_q       <= 1'b0;
      use2_q       <= 1'b0;
      writes_q     <= 1'b0;
      fwd1_q       <= 1'b0;
      fwd2_q       <= 1'b0;
      fwd_data_q   <= '0;
      out_valid_q  <= 1'b0;
      op1_q        <= '0;
      op2_q        <= '0;
      out_rd_q     <= '0;
      out_writes_q <= 1'b0;
    end else begin
      rf_enable_q <= 1'b1;
      pend        <= pend_next;

      case (state)
        IDLE: begin
          if (accept) begin
            rs1_q      <= bus.in_rs1;
            rs2_q      <= bus.in_rs2;
            rd_q       <= bus.in_rd;
            use1_q     <= bus.in_use_rs1;
            use2_q     <= bus.in_use_rs2;
            writes_q   <= bus.in_writes_rd;
            fwd1_q     <= clr_rs1;
            fwd2_q     <= clr_rs2;
            fwd_data_q <= bus.wb_data;
            state      <= READ;
          end
        end

        READ: begin
          op1_q        <= op1_sel;
          op2_q        <= op2_sel;
          out_rd_q     <= rd_q;
          out_writes_q <= writes_q;
          out_valid_q  <= 1'b1;
          state        <= OUT;
        end

        OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  // Decode handshake and read-port drive. Strobes are gated by accept so
  // nothing reads while stalled, busy or in reset.
  assign bus.in_ready  = in_ready;
  assign bus.rf_enable = rf_enable_q;
  assign bus.rf_read1  = accept && bus.in_use_rs1;
  assign bus.rf_read2  = accept && bus.in_use_rs2;
  assign bus.rf_index1 = bus.in_rs1;
  assign bus.rf_index2 = bus.in_rs2;

  // Write port is a straight pass-through from writeback.
  assign bus.rf_write       = bus.wb_valid;
  assign bus.rf_index_write = bus.wb_rd;
  assign bus.rf_data_write  = bus.wb_data;

  // Execute side.
  assign bus.out_valid     = out_valid_q;
  assign bus.out_op1       = op1_q;
  assign bus.out_op2       = op2_q;
  assign bus.out_rd        = out_rd_q;
  assign bus.out_writes_rd = out_writes_q;

endmodule

// File: tb/tb_operand_fetch.sv
// ---------------------------------------------------------------------------
// tb_operand_fetch
//   Directed bench for operand_fetch. A small register-file model with a
//   1-cycle registered read (read-before-write) sits on the rf ports, so a
//   same-cycle writeback is only seen through the controller's forwarding.
//   Unwritten registers hold 0xBAD0_00nn so stale reads stand out.
// ---------------------------------------------------------------------------
module tb_operand_fetch;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  operand_fetch_if #(.XLEN(32), .IW(5)) bus ();

  operand_fetch #(.XLEN(32), .NREG(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [31:0] regs [32];
  int n_cmp = 0;
  int n_bad = 0;

  // Register-file model.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= (i == 0) ? 32'h0 : (32'hBAD0_0000 + 32'(i));
      end
      bus.rf_data1 <= '0;
      bus.rf_data2 <= '0;
    end else begin
      if (bus.rf_read1) bus.rf_data1 <= regs[bus.rf_index1];
      if (bus.rf_read2) bus.rf_data2 <= regs[bus.rf_index2];
      if (bus.rf_write && (bus.rf_index_write != 5'd0)) begin
        regs[bus.rf_index_write] <= bus.rf_data_write;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic u1, input logic u2, input logic w);
    bus.in_valid     = v;
    bus.in_rs1       = rs1;
    bus.in_rs2       = rs2;
    bus.in_rd        = rd;
    bus.in_use_rs1   = u1;
    bus.in_use_rs2   = u2;
    bus.in_writes_rd = w;
  endtask

  // Present an instruction, wait (bounded) for in_ready, take the accept edge.
  task automatic issue(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic u1, input logic u2, input logic w);
    set_in(1'b1, rs1, rs2, rd, u1, u2, w);
    #1;
    for (int i = 0; i < 20 && !bus.in_ready; i++) tick();
    check({tag, "_accept"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Called right after the accept edge: expects READ now, OUT next cycle.
  task automatic collect(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                         input logic [4:0] erd, input logic ew);
    check({tag, "_read_valid"}, 32'(bus.out_valid), 32'd0);
    tick();
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_op1"}, bus.out_op1, e1);
    check({tag, "_op2"}, bus.out_op2, e2);
    check({tag, "_rd"}, 32'(bus.out_rd), 32'(erd));
    check({tag, "_wr"}, 32'(bus.out_writes_rd), 32'(ew));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst          = 1'b0;
    bus.out_ready = 1'b0;
    bus.wb_valid = 1'b0;
    bus.wb_rd    = '0;
    bus.wb_data  = '0;
    set_in(1'b1, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);

    // Reset state: a valid instruction is presented but must not be taken.
    tick();
    tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_op1", bus.out_op1, 32'd0);
    check("rst_op2", bus.out_op2, 32'd0);
    check("rst_rd", 32'(bus.out_rd), 32'd0);
    check("rst_wr", 32'(bus.out_writes_rd), 32'd0);
    check("rst_rf_enable", 32'(bus.rf_enable), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_rf_read1", 32'(bus.rf_read1), 32'd0);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    check("rf_enable_up", 32'(bus.rf_enable), 32'd1);
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // Writeback x5 and check the write-port pass-through.
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd5;
    bus.wb_data  = 32'hDEAD_BEEF;
    #1;
    check("wp_write", 32'(bus.rf_write), 32'd1);
    check("wp_index", 32'(bus.rf_index_write), 32'd5);
    check("wp_data", bus.rf_data_write, 32'hDEAD_BEEF);
    tick();
    bus.wb_valid = 1'b0;

    // rs1=x5, rs2=x0: read strobes in the accept cycle, 2-cycle latency.
    set_in(1'b1, 5'd5, 5'd0, 5'd1, 1'b1, 1'b1, 1'b0);
    #1;
    check("t1_in_ready", 32'(bus.in_ready), 32'd1);
    check("t1_rf_read1", 32'(bus.rf_read1), 32'd1);
    check("t1_rf_index1", 32'(bus.rf_index1), 32'd5);
    check("t1_rf_read2", 32'(bus.rf_read2), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("t1_no_read_after", 32'(bus.rf_read1), 32'd0);
    collect("t1", 32'hDEAD_BEEF, 32'd0, 5'd1, 1'b0);

    // RAW stall on x7, released and forwarded by the writeback cycle.
    issue("t2a", 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1);
    collect("t2a", 32'd0, 32'd0, 5'd7, 1'b1);
    set_in(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
    #1;
    check("t2_stall0", 32'(bus.in_ready), 32'd0);
    tick();
    check("t2_stall1", 32'(bus.in_ready), 32'd0);
    tick();
    check("t2_stall2", 32'(bus.in_ready), 32'd0);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd7;
    bus.wb_data  = 32'h0000_1234;
    #1;
    check("t2_wb_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.wb_valid = 1'b0;
    bus.in_valid = 1'b0;
    collect("t2b", 32'h0000_1234, 32'd0, 5'd8, 1'b0);

    // Same-cycle writeback to x3 with no pending bit: op2 is forwarded.
    set_in(1'b1, 5'd5, 5'd3, 5'd12, 1'b1, 1'b1, 1'b0);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd3;
    bus.wb_data  = 32'hCAFE_F00D;
    #1;
    check("t3_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.wb_valid = 1'b0;
    bus.in_valid = 1'b0;
    collect("t3", 32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd12, 1'b0);

    // Backpressure: out_ready low for 5 cycles, a new instruction waiting.
    issue("t4", 5'd3, 5'd5, 5'd10, 1'b1, 1'b1, 1'b0);
    tick();
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t4_hold_valid", 32'(bus.out_valid), 32'd1);
      check("t4_hold_op1", bus.out_op1, 32'hCAFE_F00D);
      check("t4_hold_op2", bus.out_op2, 32'hDEAD_BEEF);
      check("t4_hold_rd", 32'(bus.out_rd), 32'd10);
      check("t4_hold_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("t4_release_valid", 32'(bus.out_valid), 32'd0);
    check("t4_release_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0;

    // WAW on x9 released by a same-cycle writeback; set wins over clear.
    issue("t5a", 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1);
    collect("t5a", 32'd0, 32'd0, 5'd9, 1'b1);
    set_in(1'b1, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1);
    #1;
    check("t5_waw_stall", 32'(bus.in_ready), 32'd0);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd9;
    bus.wb_data  = 32'h0000_0055;
    #1;
    check("t5_waw_release", 32'(bus.in_ready), 32'd1);
    tick();
    bus.wb_valid = 1'b0;
    bus.in_valid = 1'b0;
    collect("t5b", 32'd0, 32'd0, 5'd9, 1'b1);
    set_in(1'b0, 5'd9, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0);
    #1;
    check("t5_pend9_set", 32'(bus.in_ready), 32'd0);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd9;
    bus.wb_data  = 32'h0000_0099;
    tick();
    bus.wb_valid = 1'b0;
    #1;
    check("t5_pend9_clear", 32'(bus.in_ready), 32'd1);
    issue("t5c", 5'd9, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0);
    collect("t5c", 32'h0000_0099, 32'd0, 5'd13, 1'b0);

    // rd=x0 with writes_rd never marks anything pending.
    issue("t5d", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    collect("t5d", 32'd0, 32'd0, 5'd0, 1'b1);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
    #1;
    check("t5_x0_no_pend", 32'(bus.in_ready), 32'd1);

    // Reset during READ drops the instruction and clears the scoreboard.
    issue("t6a", 5'd5, 5'd0, 5'd11, 1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    #1;
    check("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    check("t6_rst_ready", 32'(bus.in_ready), 32'd0);
    check("t6_rst_enable", 32'(bus.rf_enable), 32'd0);
    tick();
    check("t6_rst_no_out", 32'(bus.out_valid), 32'd0);
    rst = 1'b1;
    tick();
    check("t6_enable_again", 32'(bus.rf_enable), 32'd1);
    set_in(1'b0, 5'd11, 5'd0, 5'd14, 1'b1, 1'b0, 1'b0);
    #1;
    check("t6_pend_cleared", 32'(bus.in_ready), 32'd1);
    issue("t6b", 5'd11, 5'd0, 5'd14, 1'b1, 1'b0, 1'b0);
    collect("t6b", 32'hBAD0_000B, 32'd0, 5'd14, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Requester-side controller for the core's 32x32 register file (2 registered read ports, 1 write port, 1-cycle read latency).
- Accepts decoded instructions on a valid/ready handshake and issues register-file reads.
- Forwards same-cycle writeback data and tracks pending destination writes with a scoreboard.
- Delivers operand pairs to execute on a second valid/ready handshake.
- Also owns the register-file write port, fed from writeback.

Parameters:
- XLEN, 32, operand/data width.
- NREG, 32, architectural register count; index width is log2(NREG)=5.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- in_valid  input  1  decoded instruction valid
- in_ready  output  1  controller can accept the instruction this cycle
- in_rs1  input  5  source 1 index
- in_rs2  input  5  source 2 index
- in_rd  input  5  destination index
- in_use_rs1  input  1  source 1 is read
- in_use_rs2  input  1  source 2 is read
- in_writes_rd  input  1  instruction will write in_rd
- rf_enable  output  1  register-file enable
- rf_read1  output  1  register-file read strobe, port 1
- rf_read2  output  1  register-file read strobe, port 2
- rf_index1  output  5  register-file read index, port 1
- rf_index2  output  5  register-file read index, port 2
- rf_data1  input  32  registered read data, port 1
- rf_data2  input  32  registered read data, port 2
- rf_write  output  1  register-file write strobe
- rf_index_write  output  5  register-file write index
- rf_data_write  output  32  register-file write data
- wb_valid  input  1  writeback valid
- wb_rd  input  5  writeback destination
- wb_data  input  32  writeback data
- out_valid  output  1  operands valid
- out_ready  input  1  execute accepts the operands
- out_op1  output  32  operand 1
- out_op2  output  32  operand 2
- out_rd  output  5  destination, passed through
- out_writes_rd  output  1  write flag, passed through

Behaviour:
- Reset (rst low, async):
  - state=IDLE, scoreboard cleared.
  - out_valid=0, out_op1=0, out_op2=0, out_rd=0, out_writes_rd=0.
  - rf_read1=0, rf_read2=0, rf_enable=0, captured forwarding flags cleared.
  - Reset mid-transaction drops the in-flight instruction; no output is produced for it.
- rf_enable is registered: 0 in reset, 1 from the first clk edge after rst deasserts.
- Write port is combinational pass-through: rf_write=wb_valid, rf_index_write=wb_rd, rf_data_write=wb_data.
- Scoreboard: pend[31:0].
  - pend[0] is always 0.
  - Bit is set on accept when in_writes_rd=1 and in_rd!=0.
  - Bit is cleared on wb_valid for wb_rd.
  - Set and clear of the same bit in the same cycle: set wins.
- Clearing term: clr(r) = wb_valid && wb_rd==r.
- Hazard:
  - (in_use_rs1 && pend[rs1] && !clr(rs1)), or
  - (in_use_rs2 && pend[rs2] && !clr(rs2)), or
  - (in_writes_rd && pend[rd] && !clr(rd)); this last term is the WAW stall.
- in_ready = (state==IDLE) && rf_enable && !hazard. Accept = in_valid && in_ready.
- FSM:
  - IDLE: on accept, drive rf_read1=in_use_rs1, rf_read2=in_use_rs2, rf_index1=in_rs1, rf_index2=in_rs2 (combinational in the accept cycle). Latch rs1, rs2, use flags, rd, writes_rd. Latch forwarding flags fwdN=clr(rsN) and fwd data=wb_data. Go to READ.
  - Forwarding is required because a same-cycle register-file write is not visible to the read issued in that cycle.
  - READ: rf_data1/2 are valid this cycle. Per operand, in priority order: index 0 or use=0 -> 0; fwd -> latched wb_data; else rf_data. Register the results into out_op1/2, out_rd, out_writes_rd; set out_valid. Go to OUT.
  - OUT: hold all outputs stable while out_valid && !out_ready. On out_ready: out_valid=0 next cycle, go to IDLE.
- Throughput and latency:
  - Accept-to-out_valid latency is 2 cycles.
  - Best case is one instruction per 3 cycles.
- in_valid while not ready: the instruction is not consumed; upstream holds it stable.
- Writebacks arriving in READ/OUT update the scoreboard normally; they cannot affect captured operands, since the scoreboard guarantees no pending writer for a non-forwarded source.

Test Plan:
- Reset, then write x5=0xDEADBEEF via wb; issue rs1=5, rs2=0 -> 2 cycles after accept: out_valid=1, op1=0xDEADBEEF, op2=0.
- Issue rd=7, writes_rd=1 (pend[7] set); next instruction rs1=7 -> in_ready=0 until wb_rd=7, data=0x1234. In the wb cycle the instruction is accepted and op1=0x1234 via forwarding.
- wb_rd=3 in the same cycle as an accept reading rs2=3 with no pending bit -> op2 = that cycle's wb_data, not the stale register-file value.
- Hold out_ready=0 for 5 cycles -> out_valid, op1, op2, rd stable; in_ready=0 throughout; release -> out_valid drops next cycle, in_ready=1.
- Accept rd=9 in the same cycle as wb_rd=9 clears the old write -> pend[9]=1 afterwards. in_rd=0 with writes_rd=1 -> pend unchanged.
- Assert rst low during READ -> out_valid=0, pend=0, state IDLE immediately; after release, the first accept proceeds normally.
